// File: rtl/raster_pkg.sv
// raster_pkg: shared geometry constants, widths and engine state enums
// for the 640x480 1-bit double-buffered raster core.
package raster_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIXELS   = 307200;

  localparam int ADDR_W = 19;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  localparam logic [X_W-1:0]    X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(PIXELS - 1);

  typedef enum logic {
    F_IDLE,
    F_FILL
  } fill_state_t;

  typedef enum logic {
    L_IDLE,
    L_DRAW
  } line_state_t;

  // Linear pixel address y*640+x as y*512 + y*128 + x.
  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 9) + (yw << 7) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/raster_line_engine.sv
// raster_line_engine: Bresenham line walker, one pixel per cycle.
// Ports: clk, rst, start, x1/y1/x2/y2 endpoints, ready, write bus
// (we, addr, data) that is all-zero while idle. Optional macro
// RASTER_CLIP_EN masks we for pixels outside 640x480.
module raster_line_engine
  import raster_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y1,
  input  logic [X_W-1:0]    x2,
  input  logic [Y_W-1:0]    y2,
  output logic              ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              data
);

  line_state_t        state;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic signed [11:0] err;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic               sx;
  logic               sy;
  logic [X_W-1:0]     rem;

  logic [X_W-1:0]     adx;
  logic [Y_W-1:0]     ady;
  logic [X_W-1:0]     len;
  logic signed [12:0] e2;
  logic signed [12:0] dx_w;
  logic signed [12:0] dy_w;
  logic               step_x;
  logic               step_y;
  logic signed [11:0] err_n;
  logic               draw;
  logic               visible;

  assign adx = (x2 >= x1) ? x2 - x1 : x1 - x2;
  assign ady = (y2 >= y1) ? y2 - y1 : y1 - y2;
  // Remaining-step counter bounds the walk even for odd endpoints.
  assign len = (adx > X_W'(ady)) ? adx : X_W'(ady);

  // dy is held negative, so err = dx + dy starts the classic form.
  assign e2     = 13'(err) <<< 1;
  assign dx_w   = 13'(dx);
  assign dy_w   = 13'(dy);
  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);

  always_comb begin
    err_n = err;
    if (step_x) err_n = err_n + dy;
    if (step_y) err_n = err_n + dx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= L_IDLE;
      x     <= '0;
      y     <= '0;
      err   <= '0;
      dx    <= '0;
      dy    <= '0;
      sx    <= 1'b0;
      sy    <= 1'b0;
      rem   <= '0;
    end else begin
      unique case (state)
        L_IDLE: begin
          if (start) begin
            state <= L_DRAW;
            x     <= x1;
            y     <= y1;
            dx    <= 12'(adx);
            dy    <= -12'(ady);
            err   <= 12'(adx) - 12'(ady);
            sx    <= (x2 < x1);
            sy    <= (y2 < y1);
            rem   <= len;
          end
        end
        L_DRAW: begin
          if (rem == '0) begin
            state <= L_IDLE;
          end else begin
            rem <= rem - 1'b1;
            err <= err_n;
            if (step_x) x <= sx ? x - 1'b1 : x + 1'b1;
            if (step_y) y <= sy ? y - 1'b1 : y + 1'b1;
          end
        end
        default: state <= L_IDLE;
      endcase
    end
  end

`ifdef RASTER_CLIP_EN
  assign visible = (x <= X_LAST) && (y <= Y_LAST);
`else
  assign visible = 1'b1;
`endif

  assign draw  = (state == L_DRAW);
  assign ready = (state == L_IDLE);
  assign we    = draw && visible;
  assign addr  = we ? pix_addr(x, y) : '0;
  assign data  = we;

endmodule

// File: rtl/raster_core.sv
// raster_core: double-buffered 640x480x1 frame buffer with a clear
// (fill) engine and a line engine writing the back bank; the front
// bank is read with one-cycle latency and banks exchange on swap.
// Ports: clk, rst, fill_start/fill_ready, line_start/line_ready,
// x1/y1/x2/y2, read_addr/read_data, swap. Macro: RASTER_CLIP_EN.
module raster_core
  import raster_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  output logic              fill_ready,
  input  logic              line_start,
  output logic              line_ready,
  input  logic [X_W-1:0]    x1,
  input  logic [Y_W-1:0]    y1,
  input  logic [X_W-1:0]    x2,
  input  logic [Y_W-1:0]    y2,
  input  logic [ADDR_W-1:0] read_addr,
  output logic              read_data,
  input  logic              swap
);

  fill_state_t       fstate;
  logic [ADDR_W-1:0] fcnt;
  logic              front;

  logic              idle;
  logic              fill_go;
  logic              line_go;

  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_data;
  logic              line_we;
  logic [ADDR_W-1:0] line_addr;
  logic              line_data;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              data;

  logic mem0 [0:PIXELS-1];
  logic mem1 [0:PIXELS-1];

  // Fill has priority; a start is only honoured with both engines idle.
  assign idle    = fill_ready && line_ready;
  assign fill_go = fill_start && idle;
  assign line_go = line_start && idle && !fill_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate <= F_IDLE;
      fcnt   <= '0;
    end else begin
      unique case (fstate)
        F_IDLE: begin
          if (fill_go) begin
            fstate <= F_FILL;
            fcnt   <= '0;
          end
        end
        F_FILL: begin
          if (fcnt == A_LAST) fstate <= F_IDLE;
          else                fcnt   <= fcnt + 1'b1;
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  assign fill_ready = (fstate == F_IDLE);
  assign fill_we    = (fstate == F_FILL);
  assign fill_addr  = fill_we ? fcnt : '0;
  assign fill_data  = 1'b0;

  raster_line_engine u_line (
    .clk   (clk),
    .rst   (rst),
    .start (line_go),
    .x1    (x1),
    .y1    (y1),
    .x2    (x2),
    .y2    (y2),
    .ready (line_ready),
    .we    (line_we),
    .addr  (line_addr),
    .data  (line_data)
  );

  // Idle engines drive zeros, so OR-ing merges the two write ports.
  assign we   = fill_we | line_we;
  assign addr = fill_addr | line_addr;
  assign data = fill_data | line_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front     <= 1'b0;
      read_data <= 1'b0;
    end else begin
      if (swap) front <= ~front;
      if (read_addr <= A_LAST)
        read_data <= front ? mem1[read_addr] : mem0[read_addr];
      else
        read_data <= 1'b0;
    end
  end

  // Back bank is the one not selected by front; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && (addr <= A_LAST)) begin
      if (front) mem0[addr] <= data;
      else       mem1[addr] <= data;
    end
  end

endmodule

// File: tb/tb_raster_core.sv
// tb_raster_core: table-driven and random line checks against a
// bank-level pixel model, plus fill, arbitration and swap sequences.
module tb_raster_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       fill_start;
  logic       fill_ready;
  logic       line_start;
  logic       line_ready;
  logic [9:0] x1;
  logic [8:0] y1;
  logic [9:0] x2;
  logic [8:0] y2;
  logic [18:0] read_addr;
  logic       read_data;
  logic       swap;

  always #5 clk = ~clk;

  raster_core dut (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_ready (fill_ready),
    .line_start (line_start),
    .line_ready (line_ready),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .swap       (swap)
  );

  typedef struct {
    int ax;
    int ay;
    int bx;
    int by;
    int cyc;
  } vec_t;

  vec_t tv [7];

  bit mbank [2][307200];
  int mfront;
  int px[$];
  int py[$];
  int n_cmp;
  int n_bad;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic rd(int a);
    read_addr = 19'(a);
    tick;
    check($sformatf("pix[%0d]", a), int'(read_data),
          int'(mbank[mfront][a]));
  endtask

  task automatic do_swap;
    swap = 1'b1;
    tick;
    swap = 1'b0;
    mfront = 1 - mfront;
  endtask

  // Reference walk: textbook integer Bresenham over plain ints.
  function automatic void model_line(int ax, int ay, int bx, int by);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (bx > ax) ? bx - ax : ax - bx;
    dy = (by > ay) ? ay - by : by - ay;
    sx = (ax < bx) ? 1 : -1;
    sy = (ay < by) ? 1 : -1;
    err = dx + dy;
    x = ax;
    y = ay;
    px.delete();
    py.delete();
    for (int k = 0; k < 2000; k++) begin
      px.push_back(x);
      py.push_back(y);
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  task automatic draw(int ax, int ay, int bx, int by, int cyc);
    int n;
    x1 = 10'(ax);
    y1 = 9'(ay);
    x2 = 10'(bx);
    y2 = 9'(by);
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    n = 0;
    while (!line_ready && n < 2000) begin
      tick;
      n++;
    end
    check($sformatf("line_cyc(%0d,%0d)-(%0d,%0d)", ax, ay, bx, by),
          n, cyc);
    model_line(ax, ay, bx, by);
    foreach (px[i])
      if (px[i] < 640 && py[i] < 480)
        mbank[1 - mfront][py[i] * 640 + px[i]] = 1'b1;
  endtask

  // Show the back bank, read the line, its x-neighbours and samples.
  task automatic verify_line;
    int a;
    do_swap;
    foreach (px[i]) begin
      a = py[i] * 640 + px[i];
      if (px[i] < 640 && py[i] < 480) begin
        rd(a);
        if (px[i] > 0) rd(a - 1);
        if (px[i] < 639) rd(a + 1);
      end else if (a < 307200) begin
        rd(a);
      end
    end
    for (int k = 0; k < 8; k++) rd(int'($urandom_range(0, 307199)));
    do_swap;
  endtask

  initial begin
    int n;
    int ax, ay, bx, by, ddx, ddy;
    tv[0] = '{100, 50, 100, 50, 1};
    tv[1] = '{10, 20, 30, 20, 21};
    tv[2] = '{300, 400, 290, 100, 301};
    tv[3] = '{290, 100, 300, 400, 301};
    tv[4] = '{0, 0, 639, 479, 640};
    tv[5] = '{639, 0, 0, 479, 640};
    tv[6] = '{5, 479, 5, 470, 10};
    n_cmp = 0;
    n_bad = 0;
    mfront = 0;
    rst = 1'b1;
    fill_start = 1'b0;
    line_start = 1'b0;
    swap = 1'b0;
    read_addr = '0;
    x1 = '0;
    y1 = '0;
    x2 = '0;
    y2 = '0;
    repeat (3) tick;
    check("rst_fill_ready", int'(fill_ready), 1);
    check("rst_line_ready", int'(line_ready), 1);
    check("rst_read_data", int'(read_data), 0);
    rst = 1'b0;
    tick;
    rd(0);
    rd(1000);
    rd(307199);

    do_swap;
    x1 = 10'd5;
    y1 = 9'd5;
    x2 = 10'd20;
    y2 = 9'd9;
    fill_start = 1'b1;
    line_start = 1'b1;
    tick;
    fill_start = 1'b0;
    line_start = 1'b0;
    check("fill_accept", int'(fill_ready), 0);
    check("line_dropped", int'(line_ready), 1);
    n = 0;
    while (!fill_ready && n < 400000) begin
      line_start = (n == 100);
      tick;
      n++;
      if (n == 101) check("line_ignored", int'(line_ready), 1);
    end
    line_start = 1'b0;
    check("fill_cycles", n, 307200);
    for (int a = 0; a < 307200; a++) mbank[1 - mfront][a] = 1'b0;
    do_swap;
    rd(0);
    rd(1);
    rd(307199);
    model_line(5, 5, 20, 9);
    foreach (px[i]) rd(py[i] * 640 + px[i]);
    for (int k = 0; k < 16; k++) rd(int'($urandom_range(0, 307199)));

    for (int t = 0; t < 7; t++) begin
      draw(tv[t].ax, tv[t].ay, tv[t].bx, tv[t].by, tv[t].cyc);
      verify_line;
    end

    read_addr = '0;
    swap = 1'b1;
    tick;
    swap = 1'b0;
    check("swap_cycle_old_front", int'(read_data),
          int'(mbank[mfront][0]));
    mfront = 1 - mfront;
    tick;
    check("swap_next_new_front", int'(read_data),
          int'(mbank[mfront][0]));

    for (int r = 0; r < 12; r++) begin
      ax = int'($urandom_range(0, 639));
      ay = int'($urandom_range(0, 479));
      bx = int'($urandom_range(0, 639));
      by = int'($urandom_range(0, 479));
      ddx = (bx > ax) ? bx - ax : ax - bx;
      ddy = (by > ay) ? by - ay : ay - by;
      draw(ax, ay, bx, by, ((ddx > ddy) ? ddx : ddy) + 1);
      verify_line;
    end

`ifdef RASTER_CLIP_EN
    draw(630, 10, 700, 10, 71);
    verify_line;
`endif

    x1 = 10'd0;
    y1 = 9'd0;
    x2 = 10'd639;
    y2 = 9'd0;
    line_start = 1'b1;
    tick;
    line_start = 1'b0;
    repeat (5) tick;
    check("abort_busy", int'(line_ready), 0);
    rst = 1'b1;
    #1;
    check("abort_line_ready", int'(line_ready), 1);
    check("abort_fill_ready", int'(fill_ready), 1);
    check("abort_read_data", int'(read_data), 0);
    rst = 1'b0;
    repeat (3) tick;
    check("abort_stays_idle", int'(line_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
